// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity frame transmitter: FSM state encodings,
// frame overhead (start + parity + stop slots), the default data width and a
// counter-width helper used by the top and the bit timer.
package parity_frame_tx_pkg;

    // Data width expected from the upstream parity generator.
    localparam int DEF_DATA_W  = 4;

    // Non-data line slots in a frame: start, parity, stop.
    localparam int FRAME_EXTRA = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ceil(log2(n)) with a floor of one bit, so single-value counters still
    // have a real register behind them.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Purpose : times one line-bit period of CLKS_PER_BIT clocks for the frame FSM.
// Latency : bit_end is combinational from the counter, high on the last cycle of each period.
// Backpressure: none; held at count 0 while clear is high.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   clear       - hold the counter at zero (used while the line is idle)
//   bit_end     - last cycle of the current bit period
//   bit_penult  - second-to-last cycle of the period (never high when CLKS_PER_BIT=1)
module parity_frame_tx_bit_timer
    import parity_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end,
    output logic bit_penult
);

    localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wraps to zero on every bit boundary, so each state gets a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end = (r_cnt == LAST);

    // The penultimate cycle lets the FSM register a pulse that lands exactly
    // on the last cycle of a period. A one-clock period has no such cycle.
    generate
        if (CLKS_PER_BIT > 1) begin : g_penult
            assign bit_penult = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));
        end else begin : g_no_penult
            assign bit_penult = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/parity_frame_tx.sv
// Purpose : serialise a data nibble plus supplied parity as start/data(LSB first)/parity/stop, flag parity mismatch.
// Latency : tx drops to the start bit the cycle after accept; frame is (DATA_W+3)*CLKS_PER_BIT cycles.
// Backpressure: in_ready is high only in IDLE; inputs are ignored while a frame is on the line.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset (aborts any frame, tx forced high)
//   in_valid     - upstream offers a data/parity pair
//   in_ready     - pair is accepted on an edge where in_valid && in_ready
//   in_data      - data word, sent LSB first
//   in_parity    - parity bit, sent unchanged
//   tx           - registered serial line, idle high
//   busy         - a frame is in progress
//   frame_done   - one-cycle pulse on the final cycle of the stop bit
//   par_err      - one-cycle pulse in the first start-bit cycle when in_parity != ^in_data
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic              par_err
);

    localparam int               BIT_W    = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;      // remaining data bits, next one at [0]
    logic              r_parity;
    logic [BIT_W-1:0]  r_bit_idx;
    logic              r_tx;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_par_err;

    logic w_bit_end;
    logic w_bit_penult;
    logic w_clear;
    logic w_accept;

    assign w_clear  = (r_state == ST_IDLE);
    assign w_accept = in_valid && r_in_ready;

    parity_frame_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .bit_end    (w_bit_end),
        .bit_penult (w_bit_penult)
    );

    // tx is loaded with the value of the next slot on the same edge that
    // changes state, so the line moves exactly on bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_par_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_par_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_shift    <= in_data;
                        r_parity   <= in_parity;
                        // Report only; the supplied parity is still sent as-is.
                        r_par_err  <= in_parity ^ (^in_data);
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx         <= 1'b1;
                        r_state      <= ST_STOP;
                        // A one-clock stop bit is its own last cycle.
                        r_frame_done <= (CLKS_PER_BIT == 1);
                    end
                end
                ST_STOP: begin
                    r_frame_done <= w_bit_penult;
                    if (w_bit_end) begin
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign par_err    = r_par_err;

endmodule

// File: tb/tb_parity_frame_tx.sv
`timescale 1ns/1ps
// Two instances (CLKS_PER_BIT=4 and 1), each fed by its own word source and
// compared every cycle against a frame-level model: an accepted word becomes
// a list of line slots, and the expected line value is slot[pos / CLKS_PER_BIT].
module tb_parity_frame_tx;
    import parity_frame_tx_pkg::*;

    localparam int DW    = DEF_DATA_W;
    localparam int NSLOT = DW + FRAME_EXTRA;
    localparam int NCYC  = 2500;
    localparam int NDIR  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid   [2];
    logic          in_ready   [2];
    logic [DW-1:0] in_data    [2];
    logic          in_parity  [2];
    logic          tx         [2];
    logic          busy       [2];
    logic          frame_done [2];
    logic          par_err    [2];

    parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u_dut_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_parity(in_parity[0]),
        .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]), .par_err(par_err[0])
    );

    parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_parity(in_parity[1]),
        .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]), .par_err(par_err[1])
    );

    // Directed words first: plain frame, wrong parity, changing data,
    // the word interrupted by reset, then back-to-back words.
    logic [DW-1:0] dir_data [NDIR] = '{4'b0101, 4'b0111, 4'b0001, 4'b0011, 4'b1111,
                                       4'b1000, 4'b0000, 4'b1001, 4'b1110};
    logic          dir_par  [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0, 1'b1};

    // Reference model state per instance.
    int             m_clks  [2] = '{4, 1};
    int             m_pos   [2];          // -1 idle, else cycle index inside the frame
    logic           m_rdy   [2];
    logic           m_perr  [2];
    logic [NSLOT-1:0] m_slots [2];        // bit 0 = start slot ... bit NSLOT-1 = stop slot
    logic [DW-1:0]  m_cur   [2];
    int             m_k     [2];          // words accepted so far
    logic [DW-1:0]  w_data  [2];          // word waiting to be offered
    logic           w_par   [2];

    int   n_vec;
    int   n_err;
    int   rst_hold;
    logic rst_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input int d, input int cyc);
        int   flen;
        logic e_tx, e_busy, e_rdy, e_done, e_perr;
        flen = NSLOT * m_clks[d];
        if (m_pos[d] >= 0) begin
            e_tx   = m_slots[d][m_pos[d] / m_clks[d]];
            e_busy = 1'b1;
            e_rdy  = 1'b0;
            e_done = (m_pos[d] == flen - 1);
            e_perr = (m_pos[d] == 0) && m_perr[d];
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_rdy  = m_rdy[d];
            e_done = 1'b0;
            e_perr = 1'b0;
        end
        check_eq($sformatf("c%0d dut%0d tx", cyc, d),         32'(tx[d]),         32'(e_tx));
        check_eq($sformatf("c%0d dut%0d busy", cyc, d),       32'(busy[d]),       32'(e_busy));
        check_eq($sformatf("c%0d dut%0d in_ready", cyc, d),   32'(in_ready[d]),   32'(e_rdy));
        check_eq($sformatf("c%0d dut%0d frame_done", cyc, d), 32'(frame_done[d]), 32'(e_done));
        check_eq($sformatf("c%0d dut%0d par_err", cyc, d),    32'(par_err[d]),    32'(e_perr));
    endtask

    task automatic load_word(input int d);
        if (m_k[d] < NDIR) begin
            w_data[d] = dir_data[m_k[d]];
            w_par[d]  = dir_par[m_k[d]];
        end else begin
            w_data[d] = DW'($urandom);
            // Mostly correct parity, sometimes deliberately wrong.
            w_par[d]  = (^w_data[d]) ^ ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic drive(input int d);
        if (m_pos[d] >= 0 || !rst_n) begin
            // Not ready: anything on the inputs must be ignored.
            in_valid[d]  = 1'($urandom_range(0, 1));
            in_data[d]   = DW'($urandom);
            in_parity[d] = 1'($urandom_range(0, 1));
        end else begin
            in_data[d]   = w_data[d];
            in_parity[d] = w_par[d];
            in_valid[d]  = (m_k[d] < NDIR) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic model_step(input int d);
        int flen;
        flen = NSLOT * m_clks[d];
        if (m_pos[d] >= 0) begin
            m_pos[d] = (m_pos[d] == flen - 1) ? -1 : m_pos[d] + 1;
        end else begin
            if (m_rdy[d] && in_valid[d]) begin
                m_slots[d] = {1'b1, in_parity[d], in_data[d], 1'b0};
                m_perr[d]  = (in_parity[d] != (^in_data[d]));
                m_cur[d]   = in_data[d];
                m_pos[d]   = 0;
                m_k[d]++;
                load_word(d);
            end
            m_rdy[d] = 1'b1;
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rst_hold = 3;
        rst_done = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_pos[d]     = -1;
            m_rdy[d]     = 1'b0;
            m_perr[d]    = 1'b0;
            m_slots[d]   = '1;
            m_cur[d]     = '0;
            m_k[d]       = 0;
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_parity[d] = 1'b0;
            load_word(d);
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check_dut(d, cyc);

            if (!rst_n) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if (!rst_done && m_pos[0] == 13 && m_cur[0] == 4'b1111) begin
                // Slow instance is in data bit 2 of 1111: abort mid-frame.
                rst_n = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    check_eq($sformatf("rst_async dut%0d tx", d),         32'(tx[d]),         32'd1);
                    check_eq($sformatf("rst_async dut%0d busy", d),       32'(busy[d]),       32'd0);
                    check_eq($sformatf("rst_async dut%0d frame_done", d), 32'(frame_done[d]), 32'd0);
                    check_eq($sformatf("rst_async dut%0d in_ready", d),   32'(in_ready[d]),   32'd0);
                    check_eq($sformatf("rst_async dut%0d par_err", d),    32'(par_err[d]),    32'd0);
                    m_pos[d] = -1;
                    m_rdy[d] = 1'b0;
                end
                rst_hold = 3;
                rst_done = 1'b1;
            end

            for (int d = 0; d < 2; d++) drive(d);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) model_step(d);
            end
        end

        check_eq("mid_frame_reset_reached", 32'(rst_done), 32'd1);
        check_eq("dut0_frames_after_reset", 32'(m_k[0] > NDIR), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Downstream consumer of the 4-bit even-parity generator output. Accepts a data nibble plus its parity bit over a valid/ready handshake. Serialises them onto a single line as a framed word, UART-like: start bit, data bits LSB-first, parity bit, stop bit. Also cross-checks the supplied parity against the data and flags any mismatch.

Parameters:
DATA_W, 4, width of data word; must match generator input width
CLKS_PER_BIT, 4, clock cycles each line bit is held; legal range 1..255

Ports:
clk  input  1  single system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a data/parity pair to send
in_ready  output  1  block can accept a pair this cycle
in_data  input  DATA_W  data word from generator input side
in_parity  input  1  parity bit from generator output
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress (any state except IDLE)
frame_done  output  1  one-cycle pulse on the final cycle of the stop bit
par_err  output  1  one-cycle pulse when the accepted in_parity != XOR(in_data)

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - tx=1, in_ready=0, busy=0, frame_done=0, par_err=0.
  - FSM=IDLE; bit counter=0; clock counter=0.
  - After release: in_ready=1 from the first clock edge.
- Reset mid-frame aborts the frame immediately. tx returns high asynchronously and no frame_done is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - in_ready=1, tx=1.
  - Accept on the rising edge where in_valid&&in_ready. On that edge, register data, parity and the computed parity error, then go to START.
- par_err:
  - Registered at accept, so it is high in the first START cycle only.
  - The supplied in_parity is transmitted unchanged; the block never corrects it.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx=data[i], i=0..DATA_W-1, each bit held CLKS_PER_BIT cycles.
  - Go to PARITY after bit DATA_W-1.
- PARITY: tx=registered parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the last of them, then return to IDLE.
- Outputs:
  - tx is driven from a register, so it is glitch-free.
  - tx changes on the clock edge of the state/bit transition.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle inclusive. This is 28 cycles at the defaults.
- Handshake:
  - in_ready=0 in every non-IDLE state.
  - in_valid/in_data may change freely while in_ready=0 and are ignored.
  - Minimum gap between frames is one IDLE cycle (tx=1).
- Counters:
  - The clock counter is ceil(log2(CLKS_PER_BIT)) bits wide, minimum 1. It wraps to 0 on each bit boundary.
  - The bit counter is ceil(log2(DATA_W)) bits wide, minimum 1. It is cleared on entry to DATA.
- CLKS_PER_BIT=1: every state lasts exactly one cycle, and the frame is 7 cycles at DATA_W=4.
- No X may propagate to tx during or after reset.

Decomposition:
- Shared header parity_defs.vh holds:
  - FSM state encodings (3-bit localparams).
  - Frame overhead constant FRAME_EXTRA=3.
  - Default DATA_W.
- One natural sub-module, bit_timer:
  - Parameter CLKS_PER_BIT.
  - Inputs: clk, rst_n, clear.
  - Output: bit_end, which pulses on the last cycle of each bit period.
  - The FSM advances on bit_end.

Test Plan:
1. Defaults, in_data=4'b0101, in_parity=0, one valid pulse. Expect: tx = 0,1,0,1,0,0,1, each held 4 cycles; frame_done on cycle 28 after accept; par_err stays 0; in_ready=1 on cycle 29.
2. in_data=4'b0111, in_parity=0 (wrong). Expect: par_err=1 for exactly the first START cycle; parity slot on tx=0, unchanged; frame otherwise normal.
3. in_valid held high with in_data changing 4'b0001→4'b0011 during the frame. Expect: the first frame carries 0001 only; the second accept happens one IDLE cycle after frame_done and carries the value present then.
4. Assert rst_n=0 during DATA bit 2 of data 4'b1111. Expect: tx=1 within the same cycle, no frame_done, busy=0; in_ready=1 on the first edge after release; the next frame is clean.
5. CLKS_PER_BIT=1, in_data=4'b1000, in_parity=1. Expect: tx = 0,0,0,0,1,1,1 on consecutive cycles; frame_done on cycle 7.
6. Continuous back-to-back valid for 3 words 4'b0000/p0, 4'b1001/p0, 4'b1110/p1. Expect: three complete frames, each separated by exactly one tx=1 idle cycle; par_err never asserted.
